// File: rtl/spi_coeff_bank_if.sv
// Received-byte interface between the SPI slave and spi_coeff_bank.
//   frame_start : 1-cycle pulse when CS falls (already synchronised)
//   frame_end   : 1-cycle pulse when CS rises
//   rx_valid    : 1-cycle strobe, rx_data holds a complete MOSI byte
//   rx_data     : received byte
// master modport: the SPI slave side (drives). slave modport: the consumer.
interface spi_coeff_bank_if;
  logic       frame_start;
  logic       frame_end;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (output frame_start, frame_end, rx_valid, rx_data);
  modport slave  (input  frame_start, frame_end, rx_valid, rx_data);
endinterface

// File: rtl/spi_coeff_bank.sv
// spi_coeff_bank: decodes coefficient-write frames from the SPI byte stream
// and assembles the high-pass and low-pass biquad coefficient sets. Each set
// is staged, copied to a per-filter shadow once the whole frame has arrived,
// and committed atomically to the active set on the audio sample tick.
//
// Ports:
//   clk_48       : system clock, rising edge
//   reset        : asynchronous, active-high
//   rx           : byte stream from the SPI slave (spi_coeff_bank_if.slave)
//   sample_tick  : 1-cycle pulse at each audio sample boundary
//   hp_*_coeff   : active high-pass coefficients (signed, FRAC_BITS fraction)
//   lp_*_coeff   : active low-pass coefficients
//   hp_pending / lp_pending : shadow set complete, waiting for a tick
//   commit       : 1-cycle pulse after a tick that committed any set
//   err_count    : malformed-frame counter, saturates at 255
//
// Optional build macro COEFF_CHECKSUM_EN: frames carry one trailing byte equal
// to the XOR of the command byte and all payload bytes; a mismatch counts as
// an error and leaves the shadow set and pending flag untouched.
module spi_coeff_bank #(
  parameter int          NUM_COEFFS  = 5,
  parameter int          COEFF_BYTES = 8,
  parameter int          FRAC_BITS   = 62,
  parameter logic [7:0]  CMD_HP      = 8'h02,
  parameter logic [7:0]  CMD_LP      = 8'h03
) (
  input  logic                           clk_48,
  input  logic                           reset,
  spi_coeff_bank_if.slave                rx,
  input  logic                           sample_tick,
  output logic signed [COEFF_BYTES*8-1:0] hp_y1_coeff,
  output logic signed [COEFF_BYTES*8-1:0] hp_y2_coeff,
  output logic signed [COEFF_BYTES*8-1:0] hp_x0_coeff,
  output logic signed [COEFF_BYTES*8-1:0] hp_x1_coeff,
  output logic signed [COEFF_BYTES*8-1:0] hp_x2_coeff,
  output logic signed [COEFF_BYTES*8-1:0] lp_y1_coeff,
  output logic signed [COEFF_BYTES*8-1:0] lp_y2_coeff,
  output logic signed [COEFF_BYTES*8-1:0] lp_x0_coeff,
  output logic signed [COEFF_BYTES*8-1:0] lp_x1_coeff,
  output logic signed [COEFF_BYTES*8-1:0] lp_x2_coeff,
  output logic                           hp_pending,
  output logic                           lp_pending,
  output logic                           commit,
  output logic [7:0]                     err_count
);

  localparam int COEF_W  = COEFF_BYTES * 8;
  localparam int SET_W   = NUM_COEFFS * COEF_W;
  localparam int PAYLOAD = NUM_COEFFS * COEFF_BYTES;
`ifdef COEFF_CHECKSUM_EN
  localparam int LOAD_BYTES = PAYLOAD + 1;
`else
  localparam int LOAD_BYTES = PAYLOAD;
`endif
  localparam int CNT_W = $clog2(LOAD_BYTES + 1);

  // Identity filter: x0 = 1.0, everything else 0. The set is packed with the
  // first coefficient (y1) in the top bits, matching the MSB-first shift-in.
  localparam logic [COEF_W-1:0] UNITY     = COEF_W'(1) << FRAC_BITS;
  localparam logic [SET_W-1:0]  RESET_SET = SET_W'(UNITY) << ((NUM_COEFFS - 3) * COEF_W);

  typedef enum logic [2:0] {IDLE, CMD, LOAD, SKIP, CHECK} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [SET_W-1:0]   staging;
  logic [SET_W-1:0]   hp_shadow, lp_shadow;
  logic [SET_W-1:0]   hp_active, lp_active;
  logic               target_lp;
  logic               cnt_clr, cmd_take, byte_take, abort, do_check;
  logic               csum_ok, hp_load, lp_load;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic signed [COEF_W-1:0] coef_at(input logic [SET_W-1:0] set,
                                                       input int k);
    return set[(NUM_COEFFS - 1 - k) * COEF_W +: COEF_W];
  endfunction

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cnt_clr   = 1'b0;
    cmd_take  = 1'b0;
    byte_take = 1'b0;
    abort     = 1'b0;
    // The copy out of CHECK happens even if a new frame starts in that cycle:
    // the frame it belongs to was already complete.
    do_check  = (state == CHECK);
    if (rx.frame_start) begin
      state_nx = CMD;
      cnt_clr  = 1'b1;
    end else begin
      case (state)
        CMD: begin
          if (rx.rx_valid) begin
            cmd_take = 1'b1;
            state_nx = (rx.rx_data == CMD_HP || rx.rx_data == CMD_LP) ? LOAD : SKIP;
          end
        end
        LOAD: begin
          // A byte arriving with frame_end is consumed before frame_end counts.
          if (rx.rx_valid) begin
            byte_take = 1'b1;
            if (cnt == CNT_W'(LOAD_BYTES - 1)) begin
              state_nx = CHECK;
            end else if (rx.frame_end) begin
              abort    = 1'b1;
              state_nx = IDLE;
            end
          end else if (rx.frame_end) begin
            abort    = 1'b1;
            state_nx = IDLE;
          end
        end
        CHECK: state_nx = SKIP;
        SKIP:  if (rx.frame_end) state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

`ifdef COEFF_CHECKSUM_EN
  logic [7:0] csum;
  // Running XOR includes the checksum byte itself, so a good frame leaves 0.
  assign csum_ok = (csum == 8'h00);
`else
  assign csum_ok = 1'b1;
`endif

  assign hp_load = do_check & ~target_lp & csum_ok;
  assign lp_load = do_check &  target_lp & csum_ok;

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      staging    <= '0;
      target_lp  <= 1'b0;
      err_count  <= 8'd0;
      hp_shadow  <= RESET_SET;
      lp_shadow  <= RESET_SET;
      hp_active  <= RESET_SET;
      lp_active  <= RESET_SET;
      hp_pending <= 1'b0;
      lp_pending <= 1'b0;
      commit     <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      if (cnt_clr)        cnt <= '0;
      else if (byte_take) cnt <= cnt + CNT_W'(1);

      // Only payload bytes enter staging; a trailing checksum byte does not.
      if (byte_take && cnt < CNT_W'(PAYLOAD))
        staging <= {staging[SET_W-9:0], rx.rx_data};

      if (cmd_take) target_lp <= (rx.rx_data == CMD_LP);

`ifdef COEFF_CHECKSUM_EN
      if (cmd_take)       csum <= rx.rx_data;
      else if (byte_take) csum <= csum ^ rx.rx_data;
`endif

      if (abort || (do_check && !csum_ok)) err_count <= sat_inc(err_count);

      // The tick commits the shadow as it was before this edge; a set being
      // loaded on the same edge stays pending (set beats clear).
      if (sample_tick && hp_pending) hp_active <= hp_shadow;
      if (sample_tick && lp_pending) lp_active <= lp_shadow;
      if (hp_load) hp_shadow <= staging;
      if (lp_load) lp_shadow <= staging;
      hp_pending <= hp_load | (hp_pending & ~sample_tick);
      lp_pending <= lp_load | (lp_pending & ~sample_tick);
      commit     <= sample_tick & (hp_pending | lp_pending);
    end
  end

  assign hp_y1_coeff = coef_at(hp_active, 0);
  assign hp_y2_coeff = coef_at(hp_active, 1);
  assign hp_x0_coeff = coef_at(hp_active, 2);
  assign hp_x1_coeff = coef_at(hp_active, 3);
  assign hp_x2_coeff = coef_at(hp_active, 4);
  assign lp_y1_coeff = coef_at(lp_active, 0);
  assign lp_y2_coeff = coef_at(lp_active, 1);
  assign lp_x0_coeff = coef_at(lp_active, 2);
  assign lp_x1_coeff = coef_at(lp_active, 3);
  assign lp_x2_coeff = coef_at(lp_active, 4);

endmodule

// File: tb/tb_spi_coeff_bank.sv
// Testbench for spi_coeff_bank: directed frames driven through the byte
// interface, a frame-level model of the active/shadow sets, pending flags,
// commit pulse and error count, compared against the DUT on every cycle,
// plus literal expectations computed by hand.
module tb_spi_coeff_bank;

  localparam logic [63:0] UNITY = 64'h4000_0000_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b0;
  logic signed [63:0] hp_y1_coeff, hp_y2_coeff, hp_x0_coeff, hp_x1_coeff, hp_x2_coeff;
  logic signed [63:0] lp_y1_coeff, lp_y2_coeff, lp_x0_coeff, lp_x1_coeff, lp_x2_coeff;
  logic hp_pending, lp_pending, commit;
  logic [7:0] err_count;

  spi_coeff_bank_if bus ();

  spi_coeff_bank dut (
    .clk_48(clk), .reset(reset), .rx(bus), .sample_tick(sample_tick),
    .hp_y1_coeff(hp_y1_coeff), .hp_y2_coeff(hp_y2_coeff), .hp_x0_coeff(hp_x0_coeff),
    .hp_x1_coeff(hp_x1_coeff), .hp_x2_coeff(hp_x2_coeff),
    .lp_y1_coeff(lp_y1_coeff), .lp_y2_coeff(lp_y2_coeff), .lp_x0_coeff(lp_x0_coeff),
    .lp_x1_coeff(lp_x1_coeff), .lp_x2_coeff(lp_x2_coeff),
    .hp_pending(hp_pending), .lp_pending(lp_pending), .commit(commit),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Model: index 0 = HP, 1 = LP; coefficient order y1, y2, x0, x1, x2.
  logic [63:0] m_act [2][5];
  logic [63:0] m_shd [2][5];
  bit          m_pend [2];
  int          m_err;
  bit          m_commit;

  int n_checks = 0;
  int n_err = 0;
  int n_commits = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 5; k++) begin
        m_act[s][k] = (k == 2) ? UNITY : 64'd0;
        m_shd[s][k] = (k == 2) ? UNITY : 64'd0;
      end
      m_pend[s] = 1'b0;
    end
    m_err = 0;
    m_commit = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("hp_y1", 64'(hp_y1_coeff), m_act[0][0]);
      check("hp_y2", 64'(hp_y2_coeff), m_act[0][1]);
      check("hp_x0", 64'(hp_x0_coeff), m_act[0][2]);
      check("hp_x1", 64'(hp_x1_coeff), m_act[0][3]);
      check("hp_x2", 64'(hp_x2_coeff), m_act[0][4]);
      check("lp_y1", 64'(lp_y1_coeff), m_act[1][0]);
      check("lp_y2", 64'(lp_y2_coeff), m_act[1][1]);
      check("lp_x0", 64'(lp_x0_coeff), m_act[1][2]);
      check("lp_x1", 64'(lp_x1_coeff), m_act[1][3]);
      check("lp_x2", 64'(lp_x2_coeff), m_act[1][4]);
      check("hp_pending", 64'(hp_pending), 64'(m_pend[0]));
      check("lp_pending", 64'(lp_pending), 64'(m_pend[1]));
      check("commit", 64'(commit), 64'(m_commit));
      check("err_count", 64'(err_count), 64'(8'(m_err)));
      if (commit) n_commits++;
    end
  end

  // One clock: drive inputs after the falling edge, advance past the rising
  // edge, then apply the tick's effect on the model.
  task automatic step(input bit fs, input bit fe, input bit rv, input logic [7:0] rd,
                      input bit tk);
    @(negedge clk);
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.rx_valid    = rv;
    bus.rx_data     = rd;
    sample_tick     = tk;
    @(posedge clk);
    #1;
    m_commit = 1'b0;
    if (tk) begin
      for (int s = 0; s < 2; s++) begin
        if (m_pend[s]) begin
          for (int k = 0; k < 5; k++) m_act[s][k] = m_shd[s][k];
          m_pend[s] = 1'b0;
          m_commit = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Frame: command byte, n payload bytes base, base+1, ..., (checksum when
  // built with COEFF_CHECKSUM_EN and the frame is a full coefficient write),
  // one gap cycle (optionally carrying a tick), then frame_end.
  task automatic send_frame(input logic [7:0] cmd, input int n, input logic [7:0] base,
                            input bit corrupt, input bit tick_in_gap);
    logic [7:0]  b [40];
    logic [7:0]  cs;
    logic [63:0] v;
    bit          coef;
    int          s;
    coef = (cmd == 8'h02) || (cmd == 8'h03);
    s = (cmd == 8'h03) ? 1 : 0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, cmd, 1'b0);
    cs = cmd;
    for (int i = 0; i < n; i++) begin
      b[i] = 8'(int'(base) + i);
      cs = cs ^ b[i];
      step(1'b0, 1'b0, 1'b1, b[i], 1'b0);
    end
`ifdef COEFF_CHECKSUM_EN
    if (coef && n == 40) step(1'b0, 1'b0, 1'b1, cs ^ {7'd0, corrupt}, 1'b0);
`endif
    // Copy into the shadow lands one cycle after the last byte; a tick on
    // that same edge only commits what was already pending.
    step(1'b0, 1'b0, 1'b0, 8'h00, tick_in_gap);
    if (coef && n == 40) begin
      if (corrupt) m_err++;
      else begin
        for (int k = 0; k < 5; k++) begin
          v = 64'd0;
          for (int j = 0; j < 8; j++) v = {v[55:0], b[8*k+j]};
          m_shd[s][k] = v;
        end
        m_pend[s] = 1'b1;
      end
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    if (coef && n < 40) m_err++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (required finish before 200000)");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, e0;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Reset values
    check("rst_hp_x0", 64'(hp_x0_coeff), 64'h4000_0000_0000_0000);
    check("rst_lp_x0", 64'(lp_x0_coeff), 64'h4000_0000_0000_0000);
    check("rst_hp_y1", 64'(hp_y1_coeff), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);

    // Full HP frame 0x01..0x28, then commit on a tick
    send_frame(8'h02, 40, 8'h01, 1'b0, 1'b0);
    idle(2);
    check("hp_pend_before_tick", 64'(hp_pending), 64'd1);
    check("hp_y1_before_tick", 64'(hp_y1_coeff), 64'd0);
    c0 = n_commits;
    tick();
    idle(3);
    check("hp_y1_committed", 64'(hp_y1_coeff), 64'h0102030405060708);
    check("hp_x2_committed", 64'(hp_x2_coeff), 64'h2122232425262728);
    check("commit_once", 64'(n_commits - c0), 64'd1);
    check("lp_x0_unchanged", 64'(lp_x0_coeff), 64'h4000_0000_0000_0000);

    // Aborted LP frame after 17 bytes
    send_frame(8'h03, 17, 8'h50, 1'b0, 1'b0);
    tick();
    idle(2);
    check("abort_err", 64'(err_count), 64'd1);
    check("abort_lp_pend", 64'(lp_pending), 64'd0);
    check("abort_lp_y1", 64'(lp_y1_coeff), 64'd0);

    // Tick in the shadow-copy cycle: data stays pending until the next tick
    send_frame(8'h02, 40, 8'h80, 1'b0, 1'b1);
    check("race_pend", 64'(hp_pending), 64'd1);
    check("race_hp_y1_old", 64'(hp_y1_coeff), 64'h0102030405060708);
    tick();
    idle(2);
    check("race_hp_y1_new", 64'(hp_y1_coeff), 64'h8081828384858687);

    // Non-coefficient command with 32 bytes
    c0 = n_commits;
    send_frame(8'h01, 32, 8'h11, 1'b0, 1'b0);
    tick();
    idle(2);
    check("audio_cmd_err", 64'(err_count), 64'd1);
    check("audio_cmd_commits", 64'(n_commits - c0), 64'd0);

    // Two HP frames before a tick: last complete frame wins
    send_frame(8'h02, 40, 8'h10, 1'b0, 1'b0);
    send_frame(8'h02, 40, 8'h30, 1'b0, 1'b0);
    tick();
    idle(2);
    check("last_wins_y1", 64'(hp_y1_coeff), 64'h3031323334353637);
    check("last_wins_x0", 64'(hp_x0_coeff), 64'h4041424344454647);

`ifdef COEFF_CHECKSUM_EN
    send_frame(8'h03, 40, 8'hA0, 1'b0, 1'b0);
    tick();
    idle(2);
    check("csum_ok_lp_y1", 64'(lp_y1_coeff), 64'hA0A1A2A3A4A5A6A7);
    e0 = int'(err_count);
    send_frame(8'h02, 40, 8'h20, 1'b1, 1'b0);
    idle(1);
    check("csum_bad_err", 64'(err_count), 64'(e0 + 1));
    check("csum_bad_pend", 64'(hp_pending), 64'd0);
`else
    e0 = int'(err_count);
    check("err_before_reset", 64'(e0), 64'd1);
`endif

    // Reset in the middle of a frame restores everything
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
    chk_en = 1'b0;
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(2);
    check("mid_rst_hp_y1", 64'(hp_y1_coeff), 64'd0);
    check("mid_rst_hp_x0", 64'(hp_x0_coeff), 64'h4000_0000_0000_0000);
    check("mid_rst_err", 64'(err_count), 64'd0);

    // Bank still works after reset
    send_frame(8'h03, 40, 8'hC0, 1'b0, 1'b0);
    tick();
    idle(2);
    check("post_rst_lp_x2", 64'(lp_x2_coeff), 64'hE0E1E2E3E4E5E6E7);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_coeff_bank.md
Name: spi_coeff_bank

Overview:
Downstream consumer of the SPI slave's received byte stream. It decodes coefficient-write frames from the Raspberry Pi and assembles 64-bit biquad coefficients for the high-pass and low-pass sections. New coefficient sets are committed atomically on the audio sample tick, so the filters never see a partially updated set.

Parameters:
NUM_COEFFS, 5, coefficients per set; frame order is y1, y2, x0, x1, x2.
COEFF_BYTES, 8, bytes per coefficient, MSB first.
FRAC_BITS, 62, fractional bits of the coefficient format; 1.0 = 1<<FRAC_BITS.
CMD_HP, 8'h02, command byte selecting a write of the high-pass set.
CMD_LP, 8'h03, command byte selecting a write of the low-pass set.

Ports:
clk_48  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high reset.
frame_start  in  1  1-cycle pulse when CS falls (already synchronised by the SPI block).
frame_end  in  1  1-cycle pulse when CS rises.
rx_valid  in  1  1-cycle strobe; rx_data holds a complete MOSI byte.
rx_data  in  8  received byte.
sample_tick  in  1  1-cycle pulse at each audio sample boundary.
hp_y1_coeff, hp_y2_coeff, hp_x0_coeff, hp_x1_coeff, hp_x2_coeff  out  64 each  active HP coefficients, signed.
lp_y1_coeff, lp_y2_coeff, lp_x0_coeff, lp_x1_coeff, lp_x2_coeff  out  64 each  active LP coefficients, signed.
hp_pending, lp_pending  out  1 each  shadow set is complete and awaiting commit.
commit  out  1  1-cycle pulse when either set is committed.
err_count  out  8  count of malformed frames; saturates at 255.

Behaviour:
- Reset values:
  - Active and shadow x0 = 1<<FRAC_BITS (identity filter); all other coefficients = 0.
  - pending flags = 0, commit = 0, err_count = 0, state = IDLE.
- Storage:
  - One staging buffer of NUM_COEFFS*COEFF_BYTES bytes.
  - One shadow register set per filter.
  - One active register set per filter; the active set drives the outputs.
- FSM states: IDLE, CMD, LOAD, SKIP, CHECK.
  - frame_start in any state: go to CMD and clear the byte counter. A new frame always resyncs.
  - CMD, on rx_valid: if rx_data == CMD_HP or CMD_LP, latch the target and go to LOAD; otherwise go to SKIP. Non-coefficient commands (e.g. the 0x01 audio read) are not errors.
  - LOAD, on rx_valid: shift the byte into staging. The first byte is the MSB of y1. Increment the counter.
    - When the counter reaches NUM_COEFFS*COEFF_BYTES, go to CHECK.
    - frame_end before that: discard staging, err_count+1, go to IDLE.
  - CHECK: copy staging into the target shadow set, set that target's pending flag, go to SKIP. Copy latency is one cycle after the last byte.
  - SKIP: ignore rx_valid; frame_end returns to IDLE.
  - IDLE: ignore rx_valid and frame_end.
- Commit:
  - On sample_tick, each set whose pending flag = 1 copies shadow to active and clears its flag.
  - commit pulses high on the next cycle if any set was copied.
  - Outputs change only on these edges.
- Boundary conditions:
  - sample_tick coinciding with the CHECK copy: the tick commits only what was already pending. Setting the flag beats clearing it, so the new data stays pending until the next tick.
  - A second complete frame for the same set before a tick overwrites the shadow. The last complete frame wins; no error.
  - An aborted frame never alters the shadow or active sets.
  - rx_valid and frame_end in the same cycle: the byte is consumed first, then frame_end is evaluated.
  - Extra bytes after a complete set are ignored (SKIP).
  - Reset mid-frame: all state returns to reset values, including the active coefficients.

Optional Feature:
Macro COEFF_CHECKSUM_EN.
- Defined: the frame carries one extra byte after the coefficients, equal to the XOR of the command byte and all payload bytes.
  - LOAD expects NUM_COEFFS*COEFF_BYTES+1 bytes.
  - CHECK compares the checksum. On mismatch: err_count+1, shadow untouched, pending unchanged.
- Undefined: no checksum byte is expected; a byte following the payload is ignored in SKIP.

Test Plan:
1. Reset -> all hp/lp x0 = 64'h4000_0000_0000_0000, others 0, err_count = 0, pending = 0.
2. Frame CMD_HP followed by 40 bytes 0x01..0x28, then sample_tick -> hp_y1 = 64'h0102030405060708, hp_x2 = 64'h21222324_25262728; commit pulses once; LP unchanged.
3. Frame CMD_LP, 17 bytes, then frame_end -> err_count = 1, lp_pending = 0, LP outputs unchanged after sample_tick.
4. Complete HP frame with sample_tick asserted in the CHECK-copy cycle -> outputs unchanged that tick, hp_pending = 1; next sample_tick commits.
5. Frame with cmd 0x01 plus 32 bytes -> no error, no pending, no commit.
6. With COEFF_CHECKSUM_EN: correct checksum -> commit. Checksum XOR 0x01 -> err_count+1, no pending.
